// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
//   Shared definitions for the DDS wave shaper:
//     - default widths (phase, quarter-wave ROM address, output amplitude)
//     - waveform select encoding
//     - dither LFSR seed and tap mask (used only when DDS_DITHER_EN is defined)
//     - qrom_mag(): elaboration-time quarter-wave sine magnitude generator
// -----------------------------------------------------------------------------
package dds_pkg;

   localparam int DEF_PHASE_W = 28;
   localparam int DEF_ADDR_W  = 10;
   localparam int DEF_AMP_W   = 12;

   typedef enum logic [1:0] {
      WAVE_SINE   = 2'd0,
      WAVE_SQUARE = 2'd1,
      WAVE_TRI    = 2'd2,
      WAVE_SAW    = 2'd3
   } wave_e;

   // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> state bits 15,13,12,10.
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // round((2^(amp_w-1)-1) * sin(pi/2 * (i+0.5) / 2^addr_w)).
   // The half-LSB phase offset keeps all four quadrants exactly symmetric.
   // Evaluated only at elaboration; the Taylor series converges well below
   // double precision over [0, pi/2].
   function automatic int qrom_mag(input int i, input int addr_w, input int amp_w);
      real x;
      real term;
      real s;
      x    = 1.5707963267948966 * (real'(i) + 0.5) / real'(2 ** addr_w);
      term = x;
      s    = x;
      for (int k = 1; k < 12; k++) begin
         term = -term * x * x / real'((2 * k) * (2 * k + 1));
         s    = s + term;
      end
      return $rtoi(real'(2 ** (amp_w - 1) - 1) * s + 0.5);
   endfunction

endpackage

// File: rtl/sine_qrom.sv
// -----------------------------------------------------------------------------
// sine_qrom
//   Quarter-wave sine magnitude ROM with one-cycle synchronous read.
//   The table is generated at elaboration from dds_pkg::qrom_mag, so no
//   external .hex/.mif file has to be kept in step with the parameters.
//   Ports:
//     clk   in   1        read clock
//     addr  in   ADDR_W   quarter-wave index
//     mag   out  MAG_W    registered magnitude, valid one clk after addr
// -----------------------------------------------------------------------------
module sine_qrom
   import dds_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int MAG_W  = DEF_AMP_W - 1
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   output logic [MAG_W-1:0]  mag
);

   logic [MAG_W-1:0] tbl [2 ** ADDR_W];
   logic [MAG_W-1:0] mag_d;
   logic [MAG_W-1:0] mag_q;

   for (genvar i = 0; i < 2 ** ADDR_W; i++) begin : g_tbl
      localparam int MAG_VAL = qrom_mag(i, ADDR_W, MAG_W + 1);
      assign tbl[i] = MAG_W'(MAG_VAL);
   end

   always_comb begin
      mag_d = tbl[addr];
   end

   // NOTE: ROM read register has no reset; its output is only consumed when the
   // accompanying valid bit (which is reset) says so, and leaving it unreset lets
   // the tools map it into block RAM.
   always_ff @(posedge clk) begin
      mag_q <= mag_d;
   end

   assign mag = mag_q;

endmodule

// File: rtl/dds_wave_shaper.sv
// -----------------------------------------------------------------------------
// dds_wave_shaper
//   Phase-to-amplitude stage after the DDS phase accumulator. Truncates the
//   accumulator phase and produces sine / square / triangle / sawtooth as an
//   unsigned offset-binary sample. Three-stage pipeline, full throughput:
//   phase_vld sampled at edge N gives amp_vld at edge N+3.
//   Build option: define DDS_DITHER_EN to add LFSR phase dither before
//   truncation; ports and latency are the same in both builds.
//   Ports:
//     clk        in   1        system clock
//     clr_n      in   1        asynchronous active-low reset
//     phase_in   in   PHASE_W  accumulator phase, sampled when phase_vld=1
//     phase_vld  in   1        phase_in qualifier
//     wave_sel   in   2        0 sine, 1 square, 2 triangle, 3 saw
//     amp_out    out  AMP_W    sample, offset binary; holds between valids
//     amp_vld    out  1        one-cycle pulse per accepted phase
// -----------------------------------------------------------------------------
module dds_wave_shaper
   import dds_pkg::*;
#(
   parameter int PHASE_W = DEF_PHASE_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int AMP_W   = DEF_AMP_W
) (
   input  logic               clk,
   input  logic               clr_n,
   input  logic [PHASE_W-1:0] phase_in,
   input  logic               phase_vld,
   input  logic [1:0]         wave_sel,
   output logic [AMP_W-1:0]   amp_out,
   output logic               amp_vld
);

   localparam int P_W   = ADDR_W + 2;
   localparam int MAG_W = AMP_W - 1;
   localparam logic [AMP_W-1:0] MID = {1'b1, {(AMP_W - 1){1'b0}}};

   logic [PHASE_W-1:0] phase_eff;
   logic               unused_phase_bits;

`ifdef DDS_DITHER_EN
   localparam int DITH_W = (PHASE_W - P_W > 16) ? 16 : PHASE_W - P_W;
   logic [15:0] lfsr_d;
   logic [15:0] lfsr_q;

   always_comb begin
      lfsr_d = lfsr_q;
      if (phase_vld) lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) lfsr_q <= LFSR_SEED;
      else        lfsr_q <= lfsr_d;
   end

   assign phase_eff = phase_in + PHASE_W'(lfsr_q[DITH_W-1:0]);
`else
   assign phase_eff = phase_in;
`endif

   // Low phase bits below the truncation point are intentionally dropped.
   assign unused_phase_bits = ^phase_eff;

   // Stage registers. s*_neg is quadrant bit 1 (lower half of the sine).
   logic               s0_vld_d,  s0_vld_q;
   logic [1:0]         s0_sel_d,  s0_sel_q;
   logic [P_W-1:0]     s0_p_d,    s0_p_q;
   logic [AMP_W-1:0]   s0_alt_d,  s0_alt_q;
   logic               s1_vld_d,  s1_vld_q;
   logic [1:0]         s1_sel_d,  s1_sel_q;
   logic               s1_neg_d,  s1_neg_q;
   logic [ADDR_W-1:0]  s1_addr_d, s1_addr_q;
   logic [AMP_W-1:0]   s1_alt_d,  s1_alt_q;
   logic               s2_vld_d,  s2_vld_q;
   logic [1:0]         s2_sel_d,  s2_sel_q;
   logic               s2_neg_d,  s2_neg_q;
   logic [AMP_W-1:0]   s2_alt_d,  s2_alt_q;
   logic [AMP_W-1:0]   amp_out_d, amp_out_q;
   logic               amp_vld_d, amp_vld_q;
   logic [AMP_W-1:0]   tri_t;
   logic [MAG_W-1:0]   rom_mag;

   sine_qrom #(
      .ADDR_W (ADDR_W),
      .MAG_W  (MAG_W)
   ) u_qrom (
      .clk  (clk),
      .addr (s1_addr_q),
      .mag  (rom_mag)
   );

   // NOTE: every signal gets a default at the top of the block so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      // S0: truncate phase; non-sine waveforms are finished here and then
      // simply delayed so all waveforms share the same latency.
      s0_vld_d = phase_vld;
      s0_sel_d = wave_sel;
      s0_p_d   = phase_eff[PHASE_W-1 -: P_W];
      tri_t    = phase_eff[PHASE_W-2 -: AMP_W];
      s0_alt_d = MID;
      case (wave_e'(wave_sel))
         WAVE_SQUARE: s0_alt_d = phase_eff[PHASE_W-1] ? '0 : '1;
         WAVE_TRI:    s0_alt_d = phase_eff[PHASE_W-1] ? ~tri_t : tri_t;
         WAVE_SAW:    s0_alt_d = phase_eff[PHASE_W-1 -: AMP_W];
         default:     s0_alt_d = MID;
      endcase

      // S1: odd quadrants read the table backwards.
      s1_vld_d  = s0_vld_q;
      s1_sel_d  = s0_sel_q;
      s1_neg_d  = s0_p_q[P_W-1];
      s1_alt_d  = s0_alt_q;
      s1_addr_d = s0_p_q[P_W-2] ? ~s0_p_q[ADDR_W-1:0] : s0_p_q[ADDR_W-1:0];

      // S1 -> S2 runs in parallel with the synchronous ROM read.
      s2_vld_d = s1_vld_q;
      s2_sel_d = s1_sel_q;
      s2_neg_d = s1_neg_q;
      s2_alt_d = s1_alt_q;

      // Output: update only on a valid sample, otherwise hold.
      amp_vld_d = s2_vld_q;
      amp_out_d = amp_out_q;
      if (s2_vld_q) begin
         if (wave_e'(s2_sel_q) == WAVE_SINE)
            amp_out_d = s2_neg_q ? MID - {1'b0, rom_mag} : MID + {1'b0, rom_mag};
         else
            amp_out_d = s2_alt_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours regardless of statement order.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         s0_vld_q  <= 1'b0;
         s0_sel_q  <= '0;
         s0_p_q    <= '0;
         s0_alt_q  <= MID;
         s1_vld_q  <= 1'b0;
         s1_sel_q  <= '0;
         s1_neg_q  <= 1'b0;
         s1_addr_q <= '0;
         s1_alt_q  <= MID;
         s2_vld_q  <= 1'b0;
         s2_sel_q  <= '0;
         s2_neg_q  <= 1'b0;
         s2_alt_q  <= MID;
         amp_out_q <= MID;
         amp_vld_q <= 1'b0;
      end else begin
         s0_vld_q  <= s0_vld_d;
         s0_sel_q  <= s0_sel_d;
         s0_p_q    <= s0_p_d;
         s0_alt_q  <= s0_alt_d;
         s1_vld_q  <= s1_vld_d;
         s1_sel_q  <= s1_sel_d;
         s1_neg_q  <= s1_neg_d;
         s1_addr_q <= s1_addr_d;
         s1_alt_q  <= s1_alt_d;
         s2_vld_q  <= s2_vld_d;
         s2_sel_q  <= s2_sel_d;
         s2_neg_q  <= s2_neg_d;
         s2_alt_q  <= s2_alt_d;
         amp_out_q <= amp_out_d;
         amp_vld_q <= amp_vld_d;
      end
   end

   assign amp_out = amp_out_q;
   assign amp_vld = amp_vld_q;

endmodule

// File: tb/tb_dds_wave_shaper.sv
// -----------------------------------------------------------------------------
// tb_dds_wave_shaper
//   Directed test of dds_wave_shaper in its default (undithered) build:
//   reset values, sine quadrant points, square/saw/triangle edges, exact
//   3-clk latency and output hold, mid-stream reset, and a streaming sweep
//   against a $sin-based reference model.
// -----------------------------------------------------------------------------
module tb_dds_wave_shaper;

   logic        clk = 1'b0;
   logic        clr_n = 1'b1;
   logic [27:0] phase_in = '0;
   logic        phase_vld = 1'b0;
   logic [1:0]  wave_sel = '0;
   logic [11:0] amp_out;
   logic        amp_vld;

   int errors = 0;
   int checks = 0;

   dds_wave_shaper dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .phase_in  (phase_in),
      .phase_vld (phase_vld),
      .wave_sel  (wave_sel),
      .amp_out   (amp_out),
      .amp_vld   (amp_vld)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Independent reference: direct $sin, no table.
   function automatic logic [11:0] model(input logic [27:0] ph, input logic [1:0] sel);
      logic [11:0] p;
      logic [11:0] t;
      logic [9:0]  a;
      int          mag;
      p = ph[27:16];
      t = ph[26:15];
      a = p[10] ? ~p[9:0] : p[9:0];
      mag = $rtoi(2047.0 * $sin(3.14159265358979 / 2.0 * (real'(a) + 0.5) / 1024.0) + 0.5);
      case (sel)
         2'd0:    model = p[11] ? 12'(2048 - mag) : 12'(2048 + mag);
         2'd1:    model = ph[27] ? 12'd0 : 12'd4095;
         2'd2:    model = ph[27] ? ~t : t;
         default: model = p;
      endcase
   endfunction

   // One isolated sample: checks the exact N+3 latency and the hold afterwards.
   task automatic send_one(input string tag, input logic [1:0] sel,
                           input logic [27:0] ph, input int exp);
      phase_in  = ph;
      wave_sel  = sel;
      phase_vld = 1'b1;
      tick();
      phase_vld = 1'b0;
      phase_in  = '0;
      tick();
      check({tag, "_vld_n1"}, 32'(amp_vld), 0);
      tick();
      check({tag, "_vld_n2"}, 32'(amp_vld), 0);
      tick();
      check({tag, "_vld_n3"}, 32'(amp_vld), 1);
      check({tag, "_amp"}, 32'(amp_out), exp);
      tick();
      check({tag, "_vld_n4"}, 32'(amp_vld), 0);
      check({tag, "_hold"}, 32'(amp_out), exp);
   endtask

   initial begin
      logic [27:0] acc;
      int          n_in;
      int          n_out;
      int          late_vld;
      logic [1:0]  sel;
      logic [11:0] exp_q[$];

      #2 clr_n = 1'b0;
      #10;
      check("rst_amp", 32'(amp_out), 2048);
      check("rst_vld", 32'(amp_vld), 0);
      @(negedge clk);
      clr_n = 1'b1;
      tick();

      send_one("sin_0",   2'd0, 28'h0000000, 2050);
      send_one("sin_90",  2'd0, 28'h4000000, 4095);
      send_one("sin_180", 2'd0, 28'h8000000, 2046);
      send_one("sin_270", 2'd0, 28'hC000000, 1);
      send_one("sq_lo",   2'd1, 28'h7FFFFFF, 4095);
      send_one("sq_hi",   2'd1, 28'h8000000, 0);
      send_one("saw_top", 2'd3, 28'hFFFFFFF, 4095);
      send_one("saw_wrap",2'd3, 28'h0000000, 0);
      send_one("tri_a",   2'd2, 28'h7FFFFFF, 4095);
      send_one("tri_b",   2'd2, 28'h8000000, 4095);
      send_one("tri_c",   2'd2, 28'hFFFFFFF, 0);

      // Mid-stream reset: three samples in flight, output currently 0.
      for (int i = 0; i < 3; i++) begin
         phase_in  = 28'h4000000;
         wave_sel  = 2'd0;
         phase_vld = 1'b1;
         tick();
      end
      phase_vld = 1'b0;
      clr_n     = 1'b0;
      #1;
      check("midrst_amp", 32'(amp_out), 2048);
      check("midrst_vld", 32'(amp_vld), 0);
      tick();
      tick();
      clr_n = 1'b1;
      late_vld = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (amp_vld) late_vld++;
      end
      check("midrst_no_vld", 32'(late_vld), 0);
      check("midrst_amp_hold", 32'(amp_out), 2048);

      // Streaming sweep with idle gaps; wave_sel advances every 100 samples.
      acc   = '0;
      n_in  = 0;
      n_out = 0;
      for (int c = 0; c < 600; c++) begin
         if (n_in < 500 && (c % 7) != 6) begin
            sel       = 2'((n_in / 100) % 4);
            phase_in  = acc;
            wave_sel  = sel;
            phase_vld = 1'b1;
            exp_q.push_back(model(acc, sel));
            acc  = acc + 28'd26844;
            n_in++;
         end else begin
            phase_vld = 1'b0;
         end
         tick();
         if (amp_vld) begin
            n_out++;
            if (exp_q.size() == 0) check("sweep_extra_vld", 1, 0);
            else                   check("sweep", 32'(amp_out), 32'(exp_q.pop_front()));
         end
      end
      phase_vld = 1'b0;
      check("sweep_count", 32'(n_out), 32'(n_in));
      check("sweep_drained", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
